// File: rtl/startscreen_drawer_pkg.sv
// Shared video constants: default screen geometry, colour depth, address width
// and the start-screen drawer FSM encoding.
package startscreen_drawer_pkg;

  localparam int unsigned SCREEN_W_DEF = 160;
  localparam int unsigned SCREEN_H_DEF = 120;
  localparam int unsigned COLOUR_W_DEF = 9;
  localparam int unsigned ADDR_W       = 15;
  localparam int unsigned X_W          = 8;
  localparam int unsigned Y_W          = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/startscreen_drawer.sv
// Copies a full-screen image from an external ROM to the VGA adapter, one
// pixel per clock, through a two-stage pipeline that absorbs the ROM latency.
module startscreen_drawer
  import startscreen_drawer_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF,
  parameter int unsigned COLOUR_W = COLOUR_W_DEF
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  output logic [ADDR_W-1:0]   rom_address,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done
);

  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

  state_e              state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                done_q, done_d;
  logic [X_W-1:0]      s1_x_q;
  logic [Y_W-1:0]      s1_y_q;
  logic                s1_v_q;
  logic [X_W-1:0]      vx_q;
  logic [Y_W-1:0]      vy_q;
  logic [COLOUR_W-1:0] vc_q;
  logic                vp_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        x_d    = '0;
        y_d    = '0;
        addr_d = '0;
        if (start) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        // Running address counter tracks y*SCREEN_W+x without a multiplier.
        addr_d = addr_q + 1'b1;
        if (x_q == X_LAST) begin
          if (y_q == Y_LAST) begin
            state_d = ST_FLUSH;
            addr_d  = addr_q;
          end else begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        // done is raised once the last pixel has left stage 2; the FSM
        // leaves FLUSH at the end of that done cycle.
        if (done_q) begin
          state_d = ST_IDLE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end else if (vp_q && !s1_v_q) begin
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      s1_x_q  <= '0;
      s1_y_q  <= '0;
      s1_v_q  <= 1'b0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
      vp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      s1_x_q  <= x_q;
      s1_y_q  <= y_q;
      s1_v_q  <= (state_q == ST_SCAN);
      vp_q    <= s1_v_q;
      if (s1_v_q) begin
        vx_q <= s1_x_q;
        vy_q <= s1_y_q;
        vc_q <= rom_q;
      end
    end
  end

  assign rom_address = addr_q;
  assign vga_x       = vx_q;
  assign vga_y       = vy_q;
  assign vga_colour  = vc_q;
  assign vga_plot    = vp_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_startscreen_drawer.sv
// Directed bench for startscreen_drawer with a behavioural ROM (q = address[8:0]).
module tb_startscreen_drawer;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [14:0] rom_address;
  logic [8:0]  rom_q;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [8:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  int plots, dones, bad, wrapbad, wrap_seen, rebad, reentries;
  int e, prev_plot, prevx, prevy;

  logic [14:0] rom_addr_r;

  always #5 clock = ~clock;

  always @(posedge clock) rom_addr_r <= rom_address;
  assign rom_q = rom_addr_r[8:0];

  startscreen_drawer #(.SCREEN_W(160), .SCREEN_H(120), .COLOUR_W(9)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .rom_address(rom_address),
    .rom_q      (rom_q),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats(input int e0, input int plots0, input int pp);
    plots = plots0; dones = 0; bad = 0; wrapbad = 0; wrap_seen = 0;
    rebad = 0; reentries = 0; e = e0; prev_plot = pp; prevx = 0; prevy = 0;
  endtask

  // Cycle-by-cycle frame monitor; returns in the final done cycle or just after reset.
  task automatic watch(input int unsigned budget, input int stop_dones,
                       input int repulse_at, input int reset_at);
    int fin = 0;
    int drop = 0;
    int re = 0;
    for (int unsigned c = 0; c < budget && fin == 0; c++) begin
      @(posedge clock); #1;
      if (drop) begin start = 1'b0; drop = 0; end
      if (re == 1) begin
        if (busy !== 1'b0) rebad++;
        re = 2;
      end else if (re == 2) begin
        if (busy !== 1'b1 || rom_address !== 15'd0) rebad++;
        re = 0;
        reentries++;
      end
      if (vga_plot === 1'b1) begin
        if (done !== 1'b0) bad++;
        if (vga_x !== 8'(e % 160) || vga_y !== 7'(e / 160) || vga_colour !== 9'(e % 512)) bad++;
        if (prev_plot && prevx == 159 && prevy == 0) begin
          wrap_seen = 1;
          if (vga_x !== 8'd0 || vga_y !== 7'd1) wrapbad++;
        end
        plots++;
        e = (e + 1) % 19200;
        if (repulse_at > 0 && plots == repulse_at) begin start = 1'b1; drop = 1; end
      end else if (prev_plot && e != 0) begin
        bad++;
      end
      if (done === 1'b1) begin
        dones++;
        if (!(prev_plot && e == 0 && vga_plot === 1'b0)) bad++;
        if (busy !== 1'b1) bad++;
        if (dones == stop_dones) begin
          start = 1'b0;
          fin = 1;
        end else if (start) begin
          re = 1;
        end
      end
      if (reset_at > 0 && plots == reset_at) begin
        resetn = 1'b0;
        #1;
        chk("reset_plot_low", vga_plot, 0);
        chk("reset_busy_low", busy, 0);
        fin = 1;
      end
      prev_plot = vga_plot;
      prevx = vga_x;
      prevy = vga_y;
    end
    if (fin == 0) chk("timeout", 0, 1);
  endtask

  initial begin
    int extra_done;
    resetn = 1'b0;
    start  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_plot", vga_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", rom_address, 0);
    chk("rst_xyc", {vga_x, vga_y, vga_colour}, 0);

    // Frame 1: start pulse at edge k, re-pulse while busy at pixel 5000
    resetn = 1'b1;
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("k_busy", busy, 1);
    chk("k_addr", rom_address, 0);
    chk("k_plot", vga_plot, 0);
    @(posedge clock); #1;
    chk("k1_addr", rom_address, 1);
    chk("k1_plot", vga_plot, 0);
    @(posedge clock); #1;
    chk("k2_plot", vga_plot, 1);
    chk("k2_xy", {vga_x, vga_y}, 0);
    chk("k2_colour", vga_colour, 0);
    clear_stats(1, 1, 1);
    watch(19300, 1, 5000, 0);
    chk("f1_plots", plots, 19200);
    chk("f1_dones", dones, 1);
    chk("f1_pixel_errs", bad, 0);
    chk("f1_wrap_seen", wrap_seen, 1);
    chk("f1_wrap_errs", wrapbad, 0);
    @(posedge clock); #1;
    chk("idle_busy", busy, 0);
    chk("idle_plot", vga_plot, 0);
    chk("idle_addr", rom_address, 0);
    chk("idle_hold_x", vga_x, 159);
    chk("idle_hold_y", vga_y, 119);
    chk("idle_hold_colour", vga_colour, 9'h0FF);
    extra_done = 0;
    repeat (10) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) extra_done++;
    end
    chk("idle_quiet", extra_done, 0);

    // Frame 2: reset at pixel 8000
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    clear_stats(0, 0, 0);
    watch(8100, 1, 0, 8000);
    chk("rst_mid_pixel_errs", bad, 0);
    @(posedge clock); #1;
    chk("rst_mid_addr", rom_address, 0);
    chk("rst_mid_x", vga_x, 0);
    chk("rst_mid_done", done, 0);
    resetn = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("post_rst_wait_busy", busy, 0);
    chk("post_rst_wait_plot", vga_plot, 0);

    // Frames 3-4: start held high across two frames
    start = 1'b1;
    clear_stats(0, 0, 0);
    watch(38600, 2, 0, 0);
    chk("held_plots", plots, 38400);
    chk("held_dones", dones, 2);
    chk("held_pixel_errs", bad, 0);
    chk("held_reentries", reentries, 1);
    chk("held_reentry_errs", rebad, 0);
    repeat (2) @(posedge clock);
    #1;
    chk("held_stop_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
